// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: register map, CTRL bit positions, mode and FSM state encodings
package timer_counter_pkg;
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;
   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_e;
endpackage

// File: rtl/timer_counter_byte_merge.sv
// byte_merge: per-byte merge of an old and a new word under a lane mask
//   old_i  : current register contents
//   new_i  : lane-aligned write data
//   mask_i : one enable per byte lane (bit j/8 governs bit j)
//   out_o  : merged word
module byte_merge #(
   parameter int W = 32
) (
   input  logic [W-1:0]         old_i,
   input  logic [W-1:0]         new_i,
   input  logic [(W+7)/8-1:0]   mask_i,
   output logic [W-1:0]         out_o
);
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign out_o[i] = mask_i[i/8] ? new_i[i] : old_i[i];
   end
endmodule

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with level interrupt
//   clk   : system clock
//   reset : synchronous active-high reset
//   addr  : word offset (0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped)
//   we    : per-byte write enable, 0 = no write
//   wdata : lane-aligned write data
//   rdata : combinational read of the register selected by addr
//   irq   : CTRL.IM AND irq_pend
module timer_counter
   import timer_counter_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         addr,
   input  logic [3:0]         we,
   input  logic [COUNT_W-1:0] wdata,
   output logic [COUNT_W-1:0] rdata,
   output logic               irq
);
   logic [3:0]         ctrl_q, ctrl_d, ctrl_wr;
   logic [COUNT_W-1:0] preset_q, preset_d, preset_wr;
   logic [COUNT_W-1:0] count_q, count_d;
   state_e             state_q, state_d;
   logic               pend_q, pend_d, irq_q;
   logic               wr_ctrl, wr_pre, en, reload, en_clr;

   byte_merge #(.W(4)) u_ctrl_merge (
      .old_i(ctrl_q), .new_i(wdata[3:0]), .mask_i(we[0]), .out_o(ctrl_wr)
   );
   byte_merge #(.W(COUNT_W)) u_preset_merge (
      .old_i(preset_q), .new_i(wdata), .mask_i(we), .out_o(preset_wr)
   );

   assign wr_ctrl = (addr == REG_CTRL) && (we != 4'd0);
   assign wr_pre  = (addr == REG_PRESET) && (we != 4'd0);
   assign en      = ctrl_q[CTRL_EN];
   // MODE values 2 and 3 fall through to one-shot behaviour
   assign reload  = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pend_d  = pend_q;
      en_clr  = 1'b0;
      case (state_q)
         IDLE: state_d = en ? LOAD : IDLE;
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!en) state_d = IDLE;
            else if (count_q > COUNT_W'(1)) count_d = count_q - COUNT_W'(1);
            else begin
               count_d = '0;
               pend_d  = 1'b1;
               state_d = INT;
            end
         end
         INT: begin
            if (reload) begin
               pend_d  = 1'b0;
               state_d = LOAD;
            end else begin
               en_clr  = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
      // a bus write to CTRL/PRESET wins over an expiry in the same edge
      if (wr_ctrl || wr_pre) pend_d = 1'b0;
      ctrl_d = ctrl_q;
      ctrl_d[CTRL_EN] = ctrl_q[CTRL_EN] & ~en_clr;
      if (wr_ctrl) ctrl_d = ctrl_wr;
      preset_d = wr_pre ? preset_wr : preset_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         pend_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         state_q  <= state_d;
         pend_q   <= pend_d;
         irq_q    <= ctrl_d[CTRL_IM] & pend_d;
      end
   end

   assign irq   = irq_q;
   assign rdata = (addr == REG_CTRL)   ? {{(COUNT_W-4){1'b0}}, ctrl_q} :
                  (addr == REG_PRESET) ? preset_q :
                  (addr == REG_COUNT)  ? count_q : '0;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: scoreboard bench for timer_counter
module tb_timer_counter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic [3:0]  we = 4'd0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      string       tag;
      logic [1:0]  ra;
      logic [31:0] rd;
      logic        irq;
   } exp_t;
   exp_t sb[$];

   timer_counter #(.COUNT_W(32)) dut (
      .clk(clk), .reset(reset), .addr(addr), .we(we),
      .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, required one");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [1:0] ra, input logic [31:0] rd, input logic i);
      exp_t e;
      e.tag = tag; e.ra = ra; e.rd = rd; e.irq = i;
      sb.push_back(e);
   endtask

   // drive one bus cycle, then check everything expected after that edge
   task automatic tick(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
      exp_t e;
      addr = a; we = w; wdata = d;
      @(posedge clk);
      #1;
      we = 4'd0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         addr = e.ra;
         #1;
         check(e.tag, rdata, e.rd);
         check({e.tag, "_irq"}, {31'b0, irq}, {31'b0, e.irq});
      end
   endtask

   task automatic idle();
      tick(2'd0, 4'd0, 32'd0);
   endtask

   initial begin
      // reset
      reset = 1'b1;
      push("rst_ctrl", 2'd0, 0, 0);
      push("rst_pre", 2'd1, 0, 0);
      push("rst_cnt", 2'd2, 0, 0);
      push("rst_a3", 2'd3, 0, 0);
      idle();
      reset = 1'b0;

      // one-shot, PRESET=3
      push("os_pre", 2'd1, 3, 0);
      tick(2'd1, 4'hF, 32'd3);
      push("os_ctrl", 2'd0, 32'h9, 0);
      tick(2'd0, 4'hF, 32'h9);
      push("os_load", 2'd2, 0, 0);
      idle();
      for (int k = 3; k >= 1; k--) begin
         push("os_cnt", 2'd2, k, 0);
         idle();
      end
      push("os_exp", 2'd2, 0, 1);
      idle();
      push("os_endis", 2'd0, 32'h8, 1);
      idle();
      push("os_hold", 2'd2, 0, 1);
      idle();
      push("os_clr", 2'd0, 32'h8, 0);
      tick(2'd0, 4'hF, 32'h8);

      // auto-reload, PRESET=2
      tick(2'd1, 4'hF, 32'd2);
      push("ar_ctrl", 2'd0, 32'hB, 0);
      tick(2'd0, 4'hF, 32'hB);
      push("ar_load", 2'd2, 0, 0);
      idle();
      for (int p = 0; p < 3; p++) begin
         push("ar_c2", 2'd2, 2, 0);
         idle();
         push("ar_c1", 2'd2, 1, 0);
         idle();
         push("ar_int", 2'd2, 0, 1);
         idle();
         push("ar_reld", 2'd2, 0, 0);
         push("ar_en", 2'd0, 32'hB, 0);
         idle();
      end
      tick(2'd0, 4'hF, 32'h0);
      idle();

      // byte lanes and COUNT protection
      push("bl_ones", 2'd1, 32'hFFFFFFFF, 0);
      tick(2'd1, 4'hF, 32'hFFFFFFFF);
      push("bl_pre", 2'd1, 32'hFFFF1234, 0);
      tick(2'd1, 4'b0011, 32'hAABB1234);
      push("bl_cnt", 2'd2, 2, 0);
      tick(2'd2, 4'hF, 32'h55);
      push("bl_a3", 2'd3, 0, 0);
      push("bl_cnt3", 2'd2, 2, 0);
      tick(2'd3, 4'hF, 32'h77);

      // mid-count disable, then preset change
      tick(2'd1, 4'hF, 32'd10);
      tick(2'd0, 4'hF, 32'h1);
      idle();
      for (int k = 10; k >= 8; k--) begin
         push("md_cnt", 2'd2, k, 0);
         idle();
      end
      push("md_7", 2'd2, 7, 0);
      tick(2'd0, 4'hF, 32'h0);
      for (int k = 0; k < 5; k++) begin
         push("md_frz", 2'd2, 7, 0);
         idle();
      end
      push("md_pre4", 2'd1, 4, 0);
      tick(2'd1, 4'hF, 32'd4);
      tick(2'd0, 4'hF, 32'h1);
      push("md_load", 2'd2, 7, 0);
      idle();
      push("md_c4", 2'd2, 4, 0);
      idle();
      push("md_c3", 2'd2, 3, 0);
      tick(2'd0, 4'hF, 32'h0);
      idle();

      // collision: CTRL write in the INT cycle of a one-shot
      tick(2'd1, 4'hF, 32'd1);
      tick(2'd0, 4'hF, 32'h1);
      idle();
      push("co_c1", 2'd2, 1, 0);
      idle();
      push("co_int", 2'd2, 0, 0);
      idle();
      push("co_ctrl", 2'd0, 32'h9, 0);
      tick(2'd0, 4'hF, 32'h9);
      push("co_load", 2'd2, 0, 0);
      idle();
      push("co_rl", 2'd2, 1, 0);
      idle();
      push("co_exp", 2'd2, 0, 1);
      idle();
      push("co_end", 2'd0, 32'h8, 1);
      idle();

      // write vs expiry in the same edge: interrupt dropped
      tick(2'd1, 4'hF, 32'd1);
      tick(2'd0, 4'hF, 32'h9);
      idle();
      push("dr_c1", 2'd2, 1, 0);
      idle();
      push("dr_hit", 2'd2, 0, 0);
      tick(2'd1, 4'hF, 32'd1);
      push("dr_end", 2'd0, 32'h8, 0);
      idle();

      // masked expiry: IM=0
      tick(2'd0, 4'hF, 32'h1);
      idle();
      idle();
      push("im_exp", 2'd2, 0, 0);
      idle();
      push("im_end", 2'd0, 32'h0, 0);
      idle();
      push("im_hold", 2'd2, 0, 0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
